// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared constants for the fetch-stage PC sequencing controller.
//   RESET_PC    - value the PC register takes on reset (held outside pc_ctrl)
//   MULT_CYCLES - busy cycles after a mult/multu starts
//   DIV_CYCLES  - busy cycles after a div/divu starts
//   CNT_W       - busy counter width, wide enough for max(MULT_CYCLES, DIV_CYCLES)
//   PC_INC      - sequential fetch increment
package pc_ctrl_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0000_3000;
  localparam int          MULT_CYCLES = 5;
  localparam int          DIV_CYCLES  = 10;
  localparam int          CNT_W       = 4;
  localparam logic [31:0] PC_INC      = 32'd4;

endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: bundles the decode/hazard/execute inputs and PC-register
// outputs of pc_ctrl.
//   master - pipeline side: drives pc_f, hazard/redirect/mult-div inputs,
//            receives next_pc, pc_en, stall, md_busy
//   slave  - pc_ctrl side
interface pc_ctrl_if;

  logic [31:0] pc_f;
  logic        hazard_stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        md_start_e;
  logic        md_is_div_e;
  logic        md_use_d;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        stall;
  logic        md_busy;

  modport master (
    output pc_f, hazard_stall, redir_valid, redir_target,
           md_start_e, md_is_div_e, md_use_d,
    input  next_pc, pc_en, stall, md_busy
  );

  modport slave (
    input  pc_f, hazard_stall, redir_valid, redir_target,
           md_start_e, md_is_div_e, md_use_d,
    output next_pc, pc_en, stall, md_busy
  );

endinterface

// File: rtl/pc_ctrl_md_busy_cnt.sv
// md_busy_cnt: multiply/divide busy down-counter.
//   clk, Reset - system clock, synchronous active-high reset
//   start      - E-stage mult/div starting this cycle
//   is_div     - with start: 1 = div family, 0 = mult family
//   busy       - registered, high while the counter is non-zero
//
// mode | meaning
// IDLE | cnt == 0, a start loads the cycle count
// BUSY | cnt != 0, counts down to 0; starts are ignored
module md_busy_cnt
  import pc_ctrl_pkg::*;
#(
  parameter int MULT_N = MULT_CYCLES,
  parameter int DIV_N  = DIV_CYCLES,
  parameter int W      = CNT_W
) (
  input  logic clk,
  input  logic Reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  // A start that lands while busy does not restart the count.
  always_comb begin
    cnt_nxt = cnt;
    if (start && (cnt == '0)) begin
      cnt_nxt = is_div ? W'(DIV_N) : W'(MULT_N);
    end else if (cnt != '0) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  // busy is registered from the next count so it stays equal to (cnt != 0).
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage PC sequencing controller.
//   clk, Reset - system clock, synchronous active-high reset
//   bus        - pc_ctrl_if.slave: pc_f, hazard_stall, redirect request,
//                mult/div start and use flags in; next_pc, pc_en, stall,
//                md_busy out
// Merges hazard and mult/div stalls into a single PC stall, remembers a
// redirect that arrives while fetch is stalled, and selects next_pc.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int MULT_N = MULT_CYCLES,
  parameter int DIV_N  = DIV_CYCLES,
  parameter int W      = CNT_W
) (
  input logic       clk,
  input logic       Reset,
  pc_ctrl_if.slave  bus
);

  logic        md_busy;
  logic        md_stall;
  logic        stall;
  logic        pend;
  logic [31:0] pend_tgt;
  logic [31:0] next_pc;

  md_busy_cnt #(
    .MULT_N (MULT_N),
    .DIV_N  (DIV_N),
    .W      (W)
  ) u_md_busy_cnt (
    .clk    (clk),
    .Reset  (Reset),
    .start  (bus.md_start_e),
    .is_div (bus.md_is_div_e),
    .busy   (md_busy)
  );

  // md_start_e is included so a dependent instruction stalls in the very
  // cycle the operation is launched, before md_busy rises.
  assign md_stall = bus.md_use_d & (md_busy | bus.md_start_e);
  assign stall    = bus.hazard_stall | md_stall;

  // A fresh redirect always wins over a held one.
  always_comb begin
    next_pc = bus.pc_f + PC_INC;
    if (bus.redir_valid) begin
      next_pc = bus.redir_target;
    end else if (pend) begin
      next_pc = pend_tgt;
    end
  end

  // Any cycle the PC advances consumes whichever target was used, so the
  // held redirect only survives consecutive stalled cycles.
  always_ff @(posedge clk) begin
    if (Reset) begin
      pend     <= 1'b0;
      pend_tgt <= '0;
    end else if (bus.redir_valid && stall) begin
      pend     <= 1'b1;
      pend_tgt <= bus.redir_target;
    end else if (!stall) begin
      pend     <= 1'b0;
    end
  end

  assign bus.next_pc = next_pc;
  assign bus.stall   = stall;
  assign bus.pc_en   = ~stall;
  assign bus.md_busy = md_busy;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic Reset = 1'b1;

  pc_ctrl_if bus ();

  pc_ctrl dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: time-based. busy_last is the last cycle number on which
  // the mult/div unit is busy; a held redirect is a simple valid/address pair.
  int          cyc = 0;
  int          busy_last = -1;
  bit          m_pend = 1'b0;
  logic [31:0] m_tgt = '0;

  logic        m_busy;
  logic        exp_stall;
  logic [31:0] exp_next;

  always_comb begin
    m_busy    = (cyc <= busy_last);
    exp_stall = bus.hazard_stall | (bus.md_use_d & (m_busy | bus.md_start_e));
    if (bus.redir_valid)  exp_next = bus.redir_target;
    else if (m_pend)      exp_next = m_tgt;
    else                  exp_next = bus.pc_f + 32'd4;
  end

  always @(posedge clk) begin
    bit was_busy;
    bit was_stall;
    was_busy  = m_busy;
    was_stall = exp_stall;
    if (Reset) begin
      busy_last = -1;
      m_pend    = 1'b0;
      m_tgt     = '0;
    end else begin
      if (bus.md_start_e && !was_busy)
        busy_last = cyc + (bus.md_is_div_e ? DIV_CYCLES : MULT_CYCLES);
      if (bus.redir_valid && was_stall) begin
        m_pend = 1'b1;
        m_tgt  = bus.redir_target;
      end else if (!was_stall) begin
        m_pend = 1'b0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.hazard_stall = 1'b0;
    bus.redir_valid  = 1'b0;
    bus.redir_target = '0;
    bus.md_start_e   = 1'b0;
    bus.md_is_div_e  = 1'b0;
    bus.md_use_d     = 1'b0;
  endtask

  task automatic test_reset();
    bus.pc_f = RESET_PC;
    @(negedge clk);
    tests_run++;
    if (bus.pc_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pc_en: got %b want 1", bus.pc_en);
    end
    tests_run++;
    if (bus.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stall: got %b want 0", bus.stall);
    end
    tests_run++;
    if (bus.next_pc !== 32'h0000_3004) begin
      tests_failed++;
      $display("FAIL reset_next_pc: got %h want 00003004", bus.next_pc);
    end
    tests_run++;
    if (bus.md_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_md_busy: got %b want 0", bus.md_busy);
    end
    tick();
  endtask

  task automatic test_redirect();
    bus.pc_f         = 32'h0000_3004;
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h0000_3040;
    @(negedge clk);
    tests_run++;
    if (bus.next_pc !== 32'h0000_3040 || bus.pc_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL redir_direct: got next_pc=%h pc_en=%b want 00003040 1",
               bus.next_pc, bus.pc_en);
    end
    tick();
    bus.redir_valid = 1'b0;
    bus.pc_f        = 32'h0000_3040;
    @(negedge clk);
    tests_run++;
    if (bus.next_pc !== 32'h0000_3044) begin
      tests_failed++;
      $display("FAIL redir_no_pend: got %h want 00003044", bus.next_pc);
    end
    tick();
  endtask

  task automatic test_md(input bit is_div);
    int n;
    n = is_div ? DIV_CYCLES : MULT_CYCLES;
    clear_inputs();
    bus.md_start_e  = 1'b1;
    bus.md_is_div_e = is_div;
    @(negedge clk);
    tests_run++;
    if (bus.md_busy !== 1'b0 || bus.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL md_start_cycle div=%0d: got busy=%b stall=%b want 0 0",
               is_div, bus.md_busy, bus.stall);
    end
    tick();
    bus.md_start_e = 1'b0;
    bus.md_use_d   = 1'b1;
    for (int k = 1; k <= n + 2; k++) begin
      logic want;
      want = (k <= n);
      @(negedge clk);
      tests_run++;
      if (bus.md_busy !== want || bus.stall !== want || bus.pc_en !== ~want) begin
        tests_failed++;
        $display("FAIL md_busy div=%0d t+%0d: got busy=%b stall=%b pc_en=%b want busy=stall=%b",
                 is_div, k, bus.md_busy, bus.stall, bus.pc_en, want);
      end
      tick();
    end
    bus.md_use_d = 1'b0;
  endtask

  task automatic test_pending();
    clear_inputs();
    bus.pc_f         = 32'h0000_3008;
    bus.hazard_stall = 1'b1;
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h0000_3100;
    @(negedge clk);
    tests_run++;
    if (bus.stall !== 1'b1 || bus.pc_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL pend_stall: got stall=%b pc_en=%b want 1 0", bus.stall, bus.pc_en);
    end
    tick();
    bus.redir_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.next_pc !== 32'h0000_3100 || bus.stall !== 1'b1) begin
        tests_failed++;
        $display("FAIL pend_hold %0d: got next_pc=%h stall=%b want 00003100 1",
                 k, bus.next_pc, bus.stall);
      end
      tick();
    end
    bus.hazard_stall = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.next_pc !== 32'h0000_3100 || bus.pc_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL pend_release: got next_pc=%h pc_en=%b want 00003100 1",
               bus.next_pc, bus.pc_en);
    end
    tick();
    bus.pc_f = 32'h0000_3100;
    @(negedge clk);
    tests_run++;
    if (bus.next_pc !== 32'h0000_3104) begin
      tests_failed++;
      $display("FAIL pend_cleared: got %h want 00003104", bus.next_pc);
    end
    tick();
  endtask

  task automatic test_override();
    clear_inputs();
    bus.pc_f         = 32'h0000_3010;
    bus.hazard_stall = 1'b1;
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h0000_3100;
    tick();
    bus.redir_valid  = 1'b0;
    tick();
    bus.hazard_stall = 1'b0;
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h0000_3200;
    @(negedge clk);
    tests_run++;
    if (bus.next_pc !== 32'h0000_3200 || bus.pc_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL override: got next_pc=%h pc_en=%b want 00003200 1",
               bus.next_pc, bus.pc_en);
    end
    tick();
    bus.redir_valid = 1'b0;
    bus.pc_f        = 32'h0000_3200;
    @(negedge clk);
    tests_run++;
    if (bus.next_pc !== 32'h0000_3204) begin
      tests_failed++;
      $display("FAIL override_discard: got %h want 00003204", bus.next_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    bus.pc_f        = 32'h0000_3300;
    bus.md_start_e  = 1'b1;
    bus.md_is_div_e = 1'b1;
    tick();
    bus.md_start_e = 1'b0;
    repeat (4) tick();
    // counter is at 6 here
    bus.hazard_stall = 1'b1;
    bus.redir_valid  = 1'b1;
    bus.redir_target = 32'h0000_3380;
    tick();
    bus.redir_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.md_busy !== 1'b1 || bus.next_pc !== 32'h0000_3380) begin
      tests_failed++;
      $display("FAIL mid_before_reset: got busy=%b next_pc=%h want 1 00003380",
               bus.md_busy, bus.next_pc);
    end
    Reset = 1'b1;
    bus.hazard_stall = 1'b0;
    tick();
    Reset    = 1'b0;
    bus.pc_f = 32'h0000_3010;
    @(negedge clk);
    tests_run++;
    if (bus.md_busy !== 1'b0 || bus.next_pc !== 32'h0000_3014 || bus.pc_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_after_reset: got busy=%b next_pc=%h pc_en=%b want 0 00003014 1",
               bus.md_busy, bus.next_pc, bus.pc_en);
    end
    tick();
    // second start while busy must not extend the mult busy window
    bus.md_start_e  = 1'b1;
    bus.md_is_div_e = 1'b0;
    tick();
    bus.md_is_div_e = 1'b1;
    for (int k = 1; k <= MULT_CYCLES + 1; k++) begin
      logic want;
      want = (k <= MULT_CYCLES);
      if (k > 3) bus.md_start_e = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.md_busy !== want) begin
        tests_failed++;
        $display("FAIL restart_ignored t+%0d: got busy=%b want %b", k, bus.md_busy, want);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.hazard_stall = ($urandom_range(0, 3) == 0);
      bus.redir_valid  = ($urandom_range(0, 3) == 0);
      bus.redir_target = $urandom() & 32'hFFFF_FFFC;
      bus.md_start_e   = ($urandom_range(0, 6) == 0);
      bus.md_is_div_e  = $urandom_range(0, 1);
      bus.md_use_d     = ($urandom_range(0, 4) < 2);
      bus.pc_f         = (i == 7) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      Reset            = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      tests_run++;
      if (bus.next_pc !== exp_next || bus.stall !== exp_stall ||
          bus.pc_en !== ~exp_stall || bus.md_busy !== m_busy) begin
        tests_failed++;
        $display("FAIL random %0d: got next_pc=%h stall=%b pc_en=%b busy=%b want %h %b %b %b",
                 i, bus.next_pc, bus.stall, bus.pc_en, bus.md_busy,
                 exp_next, exp_stall, ~exp_stall, m_busy);
      end
      tick();
    end
    Reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    bus.pc_f = RESET_PC;
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;
    test_reset();
    test_redirect();
    test_md(1'b0);
    test_md(1'b1);
    test_pending();
    test_override();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
